// File: rtl/sopc_button_debounce_pkg.sv
// Shared definitions for the debounced button/switch PIO.
//   ADDR_W / DATA_W : Avalon-MM slave address and data widths
//   REG_*           : word offsets of the software-visible registers
//   is_write()      : write strobe decode from chipselect / write_n
package sopc_button_debounce_pkg;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 32;

  typedef logic [ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_DATA     = 3'd0;
  localparam reg_addr_t REG_RAW      = 3'd1;
  localparam reg_addr_t REG_IRQMASK  = 3'd2;
  localparam reg_addr_t REG_EDGECAP  = 3'd3;
  localparam reg_addr_t REG_RISE_EN  = 3'd4;
  localparam reg_addr_t REG_FALL_EN  = 3'd5;
  localparam reg_addr_t REG_DEBOUNCE = 3'd6;

  function automatic logic is_write(input logic cs, input logic wr_n);
    return cs & ~wr_n;
  endfunction

endpackage

// File: rtl/sopc_button_debounce_if.sv
// Avalon-MM slave bus bundle for the button PIO.
//   address    : register word address
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data
//   readdata   : registered read data (1-cycle latency)
// master drives the request side, slave returns readdata.
interface sopc_button_debounce_if;
  import sopc_button_debounce_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);

endinterface

// File: rtl/sopc_button_debounce_ch.sv
// One debounced input channel.
//   clk, reset : system clock, synchronous active-high reset
//   pin        : raw asynchronous pin
//   n_cycles   : stable-cycle count N from the DEBOUNCE register
//   sync       : synchronised pin level
//   deb        : debounced level
//   rise, fall : one-cycle registered edge strobes of deb
module sopc_button_debounce_ch #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter bit IDLE_HIGH   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pin,
  input  logic [CNT_W-1:0] n_cycles,
  output logic             sync,
  output logic             deb,
  output logic             rise,
  output logic             fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [CNT_W-1:0]       cnt;
  logic                   deb_q;

  assign sync = sync_r[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      // Everything idles at the pin's rest level, so leaving reset never
      // looks like an edge.
      sync_r <= {SYNC_STAGES{IDLE_HIGH}};
      cnt    <= '0;
      deb    <= IDLE_HIGH;
      deb_q  <= IDLE_HIGH;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pin};
      deb_q  <= deb;
      rise   <= deb & ~deb_q;
      fall   <= ~deb & deb_q;
      if (sync == deb) begin
        cnt <= '0;
      end else if (cnt >= n_cycles) begin
        // >= rather than == so that lowering N mid-count cannot strand a
        // counter above the new threshold.
        deb <= sync;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sopc_button_debounce.sv
// Debounced, edge-capturing button/switch PIO for the Nios II slave fabric.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//   in_port    : WIDTH raw asynchronous pins
//   irq        : level interrupt, |(edge_capture & irq_mask)
// Registers: DATA, RAW (RO), IRQMASK, EDGECAP (W1C), RISE_EN, FALL_EN,
// DEBOUNCE (RW); offset 7 reads zero. Unused upper bits read zero.
module sopc_button_debounce
  import sopc_button_debounce_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int DB_RESET    = 50000,
  parameter bit IDLE_HIGH   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  sopc_button_debounce_if.slave bus,
  input  logic [WIDTH-1:0]      in_port,
  output logic                  irq
);

  logic [WIDTH-1:0]  raw, deb, rise, fall;
  logic [WIDTH-1:0]  irq_mask, edge_capture, rise_en, fall_en;
  logic [WIDTH-1:0]  evt, w1c;
  logic [CNT_W-1:0]  debounce;
  logic [DATA_W-1:0] rd_nxt;
  logic              wr;
  logic              unused_wd;

  assign unused_wd = ^bus.writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    sopc_button_debounce_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W),
      .IDLE_HIGH   (IDLE_HIGH)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .pin      (in_port[i]),
      .n_cycles (debounce),
      .sync     (raw[i]),
      .deb      (deb[i]),
      .rise     (rise[i]),
      .fall     (fall[i])
    );
  end

  assign wr  = is_write(bus.chipselect, bus.write_n);
  assign evt = (rise & rise_en) | (fall & fall_en);
  assign w1c = (wr && bus.address == REG_EDGECAP) ? bus.writedata[WIDTH-1:0] : '0;
  assign irq = |(edge_capture & irq_mask);

  always_comb begin
    rd_nxt = '0;
    case (bus.address)
      REG_DATA:     rd_nxt[WIDTH-1:0] = deb;
      REG_RAW:      rd_nxt[WIDTH-1:0] = raw;
      REG_IRQMASK:  rd_nxt[WIDTH-1:0] = irq_mask;
      REG_EDGECAP:  rd_nxt[WIDTH-1:0] = edge_capture;
      REG_RISE_EN:  rd_nxt[WIDTH-1:0] = rise_en;
      REG_FALL_EN:  rd_nxt[WIDTH-1:0] = fall_en;
      REG_DEBOUNCE: rd_nxt[CNT_W-1:0] = debounce;
      default:      rd_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.readdata <= '0;
      irq_mask     <= '0;
      edge_capture <= '0;
      rise_en      <= '1;
      fall_en      <= '0;
      debounce     <= CNT_W'(DB_RESET);
    end else begin
      bus.readdata <= rd_nxt;
      // New events are OR'd in after the clear so a same-cycle event wins.
      edge_capture <= (edge_capture & ~w1c) | evt;
      if (wr) begin
        case (bus.address)
          REG_IRQMASK:  irq_mask <= bus.writedata[WIDTH-1:0];
          REG_RISE_EN:  rise_en  <= bus.writedata[WIDTH-1:0];
          REG_FALL_EN:  fall_en  <= bus.writedata[WIDTH-1:0];
          REG_DEBOUNCE: debounce <= bus.writedata[CNT_W-1:0];
          default: ;
        endcase
      end
    end
  end

endmodule
